// File: rtl/jt89_bus_if.sv
// CPU write port of the SN76489-compatible PSG: decodes latch/data bytes into tone, volume and noise registers.
// Build option: define JT89_READY_EN to add the READY wait-state counter (otherwise ready is tied high).
module jt89_bus_if #(
  parameter int unsigned WAIT_CYCLES = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clken,
  input  logic       cs_n,
  input  logic       wr_n,
  input  logic [7:0] din,
  output logic       ready,
  output logic [9:0] tone0,
  output logic [9:0] tone1,
  output logic [9:0] tone2,
  output logic [3:0] vol0,
  output logic [3:0] vol1,
  output logic [3:0] vol2,
  output logic [3:0] vol3,
  output logic [2:0] ctrl3,
  output logic       clr
);

  localparam int unsigned REG_W = 3;

  localparam logic [REG_W-1:0] REG_TONE0 = 3'b000;
  localparam logic [REG_W-1:0] REG_VOL0  = 3'b001;
  localparam logic [REG_W-1:0] REG_TONE1 = 3'b010;
  localparam logic [REG_W-1:0] REG_VOL1  = 3'b011;
  localparam logic [REG_W-1:0] REG_TONE2 = 3'b100;
  localparam logic [REG_W-1:0] REG_VOL2  = 3'b101;
  localparam logic [REG_W-1:0] REG_NOISE = 3'b110;
  localparam logic [REG_W-1:0] REG_VOL3  = 3'b111;

  logic             act;
  logic             act_l;
  logic             accept;
  logic             wr_en;
  logic             is_latch;
  logic [REG_W-1:0] latch_q;
  logic [REG_W-1:0] sel;

  assign act      = ~cs_n & ~wr_n;
  assign wr_en    = act & ~act_l & accept;
  assign is_latch = din[7];
  // A latch byte addresses its own register; a data byte reuses the last latch.
  assign sel      = is_latch ? din[6:4] : latch_q;

  // Strobe edge detector: a held strobe counts once, and one that began while busy never counts.
  always_ff @(posedge clk) begin
    if (rst) begin
      act_l <= 1'b0;
    end else begin
      act_l <= act;
    end
  end

`ifdef JT89_READY_EN
  localparam int unsigned CNT_W = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;

  assign accept = ready;

  // Busy time is counted in PSG clock-enable ticks, restarted by each accepted write.
  always_comb begin
    cnt_next = cnt;
    if (wr_en) begin
      cnt_next = CNT_W'(WAIT_CYCLES);
    end else if (clken && (cnt != '0)) begin
      cnt_next = cnt - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      ready <= 1'b1;
    end else begin
      cnt   <= cnt_next;
      ready <= (cnt_next == '0);
    end
  end
`else
  logic unused_cfg;

  assign accept     = 1'b1;
  assign ready      = 1'b1;
  assign unused_cfg = clken ^ (WAIT_CYCLES != 0);
`endif

  // Register file; clr flags every accepted write to the noise control.
  always_ff @(posedge clk) begin
    if (rst) begin
      latch_q <= REG_TONE0;
      tone0   <= 10'h000;
      tone1   <= 10'h000;
      tone2   <= 10'h000;
      vol0    <= 4'hF;
      vol1    <= 4'hF;
      vol2    <= 4'hF;
      vol3    <= 4'hF;
      ctrl3   <= 3'b000;
      clr     <= 1'b0;
    end else begin
      clr <= 1'b0;
      if (wr_en) begin
        if (is_latch) begin
          latch_q <= din[6:4];
        end
        unique case (sel)
          REG_TONE0: tone0 <= is_latch ? {tone0[9:4], din[3:0]} : {din[5:0], tone0[3:0]};
          REG_TONE1: tone1 <= is_latch ? {tone1[9:4], din[3:0]} : {din[5:0], tone1[3:0]};
          REG_TONE2: tone2 <= is_latch ? {tone2[9:4], din[3:0]} : {din[5:0], tone2[3:0]};
          REG_VOL0:  vol0  <= din[3:0];
          REG_VOL1:  vol1  <= din[3:0];
          REG_VOL2:  vol2  <= din[3:0];
          REG_VOL3:  vol3  <= din[3:0];
          REG_NOISE: begin
            ctrl3 <= din[2:0];
            clr   <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_jt89_bus_if.sv
// Directed scoreboard bench for jt89_bus_if; the busy/ready section is built only with JT89_READY_EN.
module tb_jt89_bus_if;

  logic       clk;
  logic       rst;
  logic       clken;
  logic       cs_n;
  logic       wr_n;
  logic [7:0] din;
  logic       ready;
  logic [9:0] tone0, tone1, tone2;
  logic [3:0] vol0, vol1, vol2, vol3;
  logic [2:0] ctrl3;
  logic       clr;

  jt89_bus_if #(.WAIT_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .clken(clken), .cs_n(cs_n), .wr_n(wr_n), .din(din),
    .ready(ready), .tone0(tone0), .tone1(tone1), .tone2(tone2),
    .vol0(vol0), .vol1(vol1), .vol2(vol2), .vol3(vol3), .ctrl3(ctrl3), .clr(clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [49:0] v;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  bit   cen_alt = 1'b0;

  logic [9:0] e_t0, e_t1, e_t2;
  logic [3:0] e_v0, e_v1, e_v2, e_v3;
  logic [2:0] e_c3;
  logic       e_clr;

  function automatic logic [49:0] snap();
    return {tone0, tone1, tone2, vol0, vol1, vol2, vol3, ctrl3, clr};
  endfunction

  task automatic push(input string tag);
    exp_t e;
    e.tag = tag;
    e.v   = {e_t0, e_t1, e_t2, e_v0, e_v1, e_v2, e_v3, e_c3, e_clr};
    sb.push_back(e);
  endtask

  task automatic check_out();
    exp_t e;
    logic [49:0] obs;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty observed=none expected=entry");
    end else begin
      e   = sb.pop_front();
      obs = snap();
      assert (obs === e.v) else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.v);
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (cen_alt) clken = ~clken;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (ready !== 1'b1 && n < 200) begin
      step();
      n++;
    end
    chk("wait_ready", 32'(ready), 32'd1);
  endtask

  // One CPU write, optionally holding the strobe for extra cycles.
  task automatic wr(input string tag, input logic [7:0] b, input int hold, input logic clr_exp);
    wait_ready();
    cs_n = 1'b0; wr_n = 1'b0; din = b;
    e_clr = clr_exp;
    push(tag);
    step();
    check_out();
    e_clr = 1'b0;
    for (int i = 0; i < hold; i++) begin
      step();
      push({tag, "_hold"});
      check_out();
    end
    cs_n = 1'b1; wr_n = 1'b1;
    step();
    push({tag, "_post"});
    check_out();
  endtask

  task automatic set_reset_exp();
    e_t0 = 10'h000; e_t1 = 10'h000; e_t2 = 10'h000;
    e_v0 = 4'hF; e_v1 = 4'hF; e_v2 = 4'hF; e_v3 = 4'hF;
    e_c3 = 3'b000; e_clr = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int low;
    int n;
    rst = 1'b1; clken = 1'b1; cs_n = 1'b1; wr_n = 1'b1; din = 8'h00;
    step();
    step();
    set_reset_exp();
    push("reset");
    check_out();
    chk("reset_ready", 32'(ready), 32'd1);
    rst = 1'b0;
    step();

    e_t0 = 10'h00E; wr("latch_tone0", 8'h8E, 0, 1'b0);
    e_t0 = 10'h0FE; wr("data_tone0", 8'h0F, 0, 1'b0);
    e_v3 = 4'h3;    wr("latch_vol3", 8'hF3, 0, 1'b0);
    e_c3 = 3'b101;  wr("latch_noise", 8'hE5, 0, 1'b1);
    e_c3 = 3'b010;  wr("data_noise", 8'h02, 0, 1'b1);
    e_t1 = 10'h005; wr("latch_tone1", 8'hA5, 0, 1'b0);
    e_t1 = 10'h3F5; wr("data_tone1_max", 8'h7F, 0, 1'b0);
    e_t2 = 10'h000; wr("latch_tone2", 8'hC0, 0, 1'b0);
    e_t2 = 10'h010; wr("data_tone2", 8'h01, 0, 1'b0);
    e_v1 = 4'h7;    wr("latch_vol1", 8'hB7, 0, 1'b0);
    e_v1 = 4'hC;    wr("data_vol1", 8'h0C, 0, 1'b0);
    e_v2 = 4'h9;    wr("latch_vol2", 8'hD9, 0, 1'b0);
    e_v0 = 4'h0;    wr("hold_vol0", 8'h90, 9, 1'b0);
    chk("hold_single_busy", 32'(ready), 32'd1);
    e_c3 = 3'b101;  wr("hold_noise", 8'hE5, 5, 1'b1);

    // Strobe without chip select must be ignored.
    cs_n = 1'b1; wr_n = 1'b0; din = 8'h93;
    step();
    step();
    push("no_cs");
    check_out();
    wr_n = 1'b1;
    step();

    e_c3 = 3'b111;  wr("data_noise_same", 8'h07, 0, 1'b1);
    e_c3 = 3'b111;  wr("noise_unchanged", 8'h07, 0, 1'b1);

`ifdef JT89_READY_EN
    cen_alt = 1'b1;
    wait_ready();
    clken = 1'b1;
    e_v0 = 4'h1; e_clr = 1'b0;
    cs_n = 1'b0; wr_n = 1'b0; din = 8'h91;
    push("busy_write");
    step();
    check_out();
    low = (ready === 1'b0) ? 1 : 0;
    cs_n = 1'b1; wr_n = 1'b1;
    step();
    if (ready === 1'b0) low++;
    // Strobe raised during busy and held past the end of busy: dropped.
    cs_n = 1'b0; wr_n = 1'b0; din = 8'h9A;
    n = 0;
    while (ready !== 1'b1 && n < 40) begin
      step();
      n++;
      if (ready === 1'b0) low++;
    end
    chk("ready_low_cycles", 32'(low), 32'd8);
    step(); step(); step();
    push("dropped_during_busy");
    check_out();
    chk("no_reload_after_drop", 32'(ready), 32'd1);
    cs_n = 1'b1; wr_n = 1'b1;
    step();
    cen_alt = 1'b0;
    clken = 1'b1;
    e_v0 = 4'hA; wr("after_busy_write", 8'h9A, 0, 1'b0);
`endif

    e_v0 = 4'h5; wr("pre_reset_write", 8'h95, 0, 1'b0);
`ifdef JT89_READY_EN
    chk("busy_before_reset", 32'(ready), 32'd0);
`endif
    rst = 1'b1;
    step();
    set_reset_exp();
    push("reset_mid");
    check_out();
    chk("reset_mid_ready", 32'(ready), 32'd1);
    rst = 1'b0;
    step();

    e_t0 = 10'h2A0; wr("data_after_reset", 8'h2A, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
